seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, clocked successor to the combinational 32-bit ALU.
- Registers operands on a start/done handshake and produces a registered result plus Z/N/C/V flags.
- Logic, shift, LUI and add/sub complete in one cycle; multiply (shift-add) and divide (restoring) are iterative and take WIDTH+1 cycles.
- Sits between the register-file read stage and writeback; the datapath controller holds off new work while busy is high.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two and at least 8. Localparam SHW = $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- operation  input  4  opcode, sampled with start
- sign  input  1  1 = two's-complement operands, 0 = unsigned
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B; SHW LSBs form the shift amount
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse when results are valid
- respuesta  output  WIDTH  main result: low product, or quotient
- outHigh  output  WIDTH  high product half, or remainder; 0 for other ops
- Z, N, C, V  output  1 each  zero, negative, carry, overflow flags
- err  output  1  illegal opcode, or divide by zero

Behaviour:
- Interface: clock is clk; reset is synchronous and active-high.
- Reset: all outputs 0, FSM to IDLE. Reset aborts any in-flight operation with no done pulse.
- FSM states: IDLE, RUN, FIN.
  - IDLE & start: capture A, B, operation and sign.
  - Single-cycle ops: compute, go to FIN.
  - MUL/DIV: load magnitudes (when sign=1), clear counter, go to RUN.
  - RUN: one iteration per cycle; after WIDTH iterations go to FIN.
  - FIN: apply sign correction, write outputs, pulse done, return to IDLE.
- Latency:
  - done is high 2 cycles after the start cycle for single-cycle ops.
  - done is high WIDTH+2 cycles after the start cycle for MUL/DIV.
  - busy is high in every cycle between acceptance and done, inclusive of the done cycle.
- Input handling:
  - start while busy is ignored; no queueing.
  - Operand changes after acceptance are ignored.
  - Outputs hold their values until the next done.
- Opcodes:
  - 0 PASSA, 1 PASSB, 2 AND, 3 OR, 4 XOR, 5 NOR = ~(A|B), 6 NOTA
  - 7 SLL, 8 SRL, 9 SRA (arithmetic regardless of sign)
  - 10 LUI = {A[WIDTH/2-1:0], zeros}
  - 11 ADD, 12 SUB, 13 MUL, 14 DIV
  - 15: err=1, respuesta=0, flags 0.
- Flags:
  - Z = (respuesta==0); N = respuesta[WIDTH-1] for every op.
  - Logic ops and LUI: C=V=0.
  - Shifts: C = last bit shifted out; C=0 when the shift amount is 0. V=0.
  - ADD: C = carry-out. V = signed overflow if sign=1, else V=C.
  - SUB: C = 1 when A>=B unsigned (no borrow). V = signed overflow if sign=1, else V=~C.
  - MUL: full 2*WIDTH product. C=0. V=1 when outHigh is not the sign-extension (sign=1) or zero-extension (sign=0) of respuesta.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign. C=0.
- DIV boundaries:
  - B==0: no iteration; FIN next cycle (single-cycle latency), err=1, respuesta=all ones, outHigh=A, V=0.
  - sign=1, A=-2^(WIDTH-1), B=-1: respuesta=-2^(WIDTH-1), outHigh=0, V=1; runs the full latency.
- err clears on the next done for a legal operation.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: opcode 14 uses the restoring divider as specified above.
- Undefined: divider logic is absent. Opcode 14 behaves like opcode 15: single-cycle, err=1, respuesta=0, outHigh=0, flags 0.

Test Plan:
- WIDTH=32, ADD, sign=1, A=32'h7FFFFFFF, B=1 -> done at cycle+2, respuesta=32'h80000000, N=1, V=1, C=0, Z=0.
- SUB, sign=0, A=2, B=3 -> respuesta=32'hFFFFFFFF, C=0, V=1, N=1; repeat with A=3, B=3 -> Z=1, C=1.
- MUL, sign=1, A=-3, B=7 -> done at cycle+34, respuesta=32'hFFFFFFEB, outHigh=32'hFFFFFFFF, V=0; unsigned A=B=32'h00010000 -> respuesta=0, outHigh=1, V=1, Z=1.
- DIV, sign=1, A=-7, B=2 -> respuesta=-3, outHigh=-1. B=0 -> err=1 at cycle+2, respuesta=all ones. A=32'h80000000, B=-1 -> V=1.
- Start a MUL; reassert start with new operands at cycle+5 -> ignored, original result returned. Assert reset at cycle+10 -> outputs 0, no done; a fresh SRA of 32'h80000000 by 4 -> 32'hF8000000, C=0.
- Opcode 15 -> err=1, done at cycle+2; with SEQ_ALU_DIV_EN undefined, opcode 14 gives the same response.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked ALU with start/done handshake, iterative multiply and optional divide
// SEQ_ALU_DIV_EN enables the restoring divider for opcode 14; otherwise opcode 14 is illegal.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       operation,
   input  logic             sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] respuesta,
   output logic [WIDTH-1:0] outHigh,
   output logic             Z,
   output logic             N,
   output logic             C,
   output logic             V,
   output logic             err
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, mc_q;
   logic [3:0]       op_q;
   logic             sign_q;
   logic [SHW-1:0]   cnt_q;
   logic             accept, iter_req;

   assign accept = (state == IDLE) && start && !busy;
`ifdef SEQ_ALU_DIV_EN
   assign iter_req = (operation == 4'd13) || ((operation == 4'd14) && (B != '0));
`else
   assign iter_req = (operation == 4'd13);
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = iter_req ? RUN : FIN;
         RUN:     if (cnt_q == SHW'(WIDTH-1)) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Iteration datapath: {hi_q, lo_q} is the shift-add product / remainder-quotient pair.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0] div_sh, div_df;
   assign div_sh = {hi_q, lo_q[WIDTH-1]};
   assign div_df = div_sh - {1'b0, mc_q};
`endif

   logic             neg_a, neg_b;
   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   sll_w, srl_w, sum_w, dif_w;
   logic signed [WIDTH:0] sra_w;
   logic [2*WIDTH-1:0] prod_w;
   assign neg_a  = sign_q & a_q[WIDTH-1];
   assign neg_b  = sign_q & b_q[WIDTH-1];
   assign amt    = b_q[SHW-1:0];
   assign sll_w  = {1'b0, a_q} << amt;
   assign srl_w  = {a_q, 1'b0} >> amt;
   assign sra_w  = $signed({a_q, 1'b0}) >>> amt;
   assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
   assign dif_w  = {1'b0, a_q} - {1'b0, b_q};
   assign prod_w = (neg_a ^ neg_b) ? -{hi_q, lo_q} : {hi_q, lo_q};

   logic [WIDTH-1:0] f_res, f_hi;
   logic             f_c, f_v, f_err;

   always_comb begin
      f_res = '0;
      f_hi  = '0;
      f_c   = 1'b0;
      f_v   = 1'b0;
      f_err = 1'b0;
      case (op_q)
         4'd0:  f_res = a_q;
         4'd1:  f_res = b_q;
         4'd2:  f_res = a_q & b_q;
         4'd3:  f_res = a_q | b_q;
         4'd4:  f_res = a_q ^ b_q;
         4'd5:  f_res = ~(a_q | b_q);
         4'd6:  f_res = ~a_q;
         4'd7:  begin f_res = sll_w[WIDTH-1:0]; f_c = (amt != '0) & sll_w[WIDTH]; end
         4'd8:  begin f_res = srl_w[WIDTH:1];   f_c = (amt != '0) & srl_w[0];     end
         4'd9:  begin f_res = sra_w[WIDTH:1];   f_c = (amt != '0) & sra_w[0];     end
         4'd10: f_res = {a_q[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         4'd11: begin
            f_res = sum_w[WIDTH-1:0];
            f_c   = sum_w[WIDTH];
            f_v   = sign_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]))
                           : sum_w[WIDTH];
         end
         4'd12: begin
            f_res = dif_w[WIDTH-1:0];
            f_c   = ~dif_w[WIDTH];
            f_v   = sign_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]))
                           : dif_w[WIDTH];
         end
         4'd13: begin
            f_res = prod_w[WIDTH-1:0];
            f_hi  = prod_w[2*WIDTH-1:WIDTH];
            f_v   = sign_q ? (f_hi != {WIDTH{f_res[WIDTH-1]}}) : (f_hi != '0);
         end
`ifdef SEQ_ALU_DIV_EN
         4'd14: begin
            if (b_q == '0) begin
               f_err = 1'b1;
               f_res = '1;
               f_hi  = a_q;
            end else begin
               f_res = (neg_a ^ neg_b) ? -lo_q : lo_q;
               f_hi  = neg_a ? -hi_q : hi_q;
               // Only MIN / -1 overflows; the magnitude quotient already equals MIN.
               f_v   = sign_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
            end
         end
`endif
         default: f_err = 1'b1;
      endcase
   end

   logic illegal;
`ifdef SEQ_ALU_DIV_EN
   assign illegal = (op_q == 4'd15);
`else
   assign illegal = (op_q == 4'd15) || (op_q == 4'd14);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0; b_q <= '0; hi_q <= '0; lo_q <= '0; mc_q <= '0;
         op_q <= '0; sign_q <= 1'b0; cnt_q <= '0;
         busy <= 1'b0; done <= 1'b0;
         respuesta <= '0; outHigh <= '0;
         Z <= 1'b0; N <= 1'b0; C <= 1'b0; V <= 1'b0; err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= accept;
               if (accept) begin
                  a_q    <= A;
                  b_q    <= B;
                  op_q   <= operation;
                  sign_q <= sign;
                  cnt_q  <= '0;
                  hi_q   <= '0;
                  lo_q   <= (sign & A[WIDTH-1]) ? -A : A;
                  mc_q   <= (sign & B[WIDTH-1]) ? -B : B;
               end
            end
            RUN: begin
               cnt_q <= cnt_q + 1'b1;
`ifdef SEQ_ALU_DIV_EN
               if (op_q == 4'd14) begin
                  if (!div_df[WIDTH]) begin
                     hi_q <= div_df[WIDTH-1:0];
                     lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     hi_q <= div_sh[WIDTH-1:0];
                     lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                  end
               end else
`endif
               begin
                  hi_q <= mul_sum[WIDTH:1];
                  lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
               end
            end
            FIN: begin
               done      <= 1'b1;
               respuesta <= f_res;
               outHigh   <= f_hi;
               Z         <= !illegal && (f_res == '0);
               N         <= !illegal && f_res[WIDTH-1];
               C         <= f_c;
               V         <= f_v;
               err       <= f_err;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu (WIDTH=32)
module tb_seq_alu;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, start, sign;
   logic [3:0]    operation;
   logic [W-1:0]  A, B;
   logic          busy, done, Z, N, C, V, err;
   logic [W-1:0]  respuesta, outHigh;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .operation(operation), .sign(sign),
      .A(A), .B(B), .busy(busy), .done(done), .respuesta(respuesta), .outHigh(outHigh),
      .Z(Z), .N(N), .C(C), .V(V), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic        z, n, c, v, e;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic sg, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      longint sa, sb, t;
      logic [63:0] p;
      int sh, ia, ib;
      e.res = '0; e.hi = '0; e.c = 0; e.v = 0; e.e = 0; e.lat = 2;
      sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
      sh = int'(b[4:0]);
      case (op)
         4'd0:  e.res = a;
         4'd1:  e.res = b;
         4'd2:  e.res = a & b;
         4'd3:  e.res = a | b;
         4'd4:  e.res = a ^ b;
         4'd5:  e.res = ~(a | b);
         4'd6:  e.res = ~a;
         4'd7:  begin e.res = a << sh; if (sh != 0) e.c = a[32-sh]; end
         4'd8:  begin e.res = a >> sh; if (sh != 0) e.c = a[sh-1]; end
         4'd9:  begin e.res = 32'($signed(a) >>> sh); if (sh != 0) e.c = a[sh-1]; end
         4'd10: e.res = {a[15:0], 16'h0000};
         4'd11: begin
            e.res = a + b;
            t = longint'({32'b0, a}) + longint'({32'b0, b});
            e.c = t[32];
            e.v = sg ? ((sa + sb) > 64'sd2147483647 || (sa + sb) < -64'sd2147483648) : e.c;
         end
         4'd12: begin
            e.res = a - b;
            e.c = (a >= b);
            e.v = sg ? ((sa - sb) > 64'sd2147483647 || (sa - sb) < -64'sd2147483648) : !e.c;
         end
         4'd13: begin
            p = sa * sb;
            e.res = p[31:0];
            e.hi  = p[63:32];
            e.v = sg ? (longint'($signed(p[31:0])) != longint'(p)) : (p[63:32] != 0);
            e.lat = 34;
         end
`ifdef SEQ_ALU_DIV_EN
         4'd14: begin
            if (b == 0) begin
               e.e = 1; e.res = '1; e.hi = a;
            end else if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               e.res = 32'h80000000; e.hi = 0; e.v = 1; e.lat = 34;
            end else if (sg) begin
               ia = a; ib = b;
               e.res = ia / ib; e.hi = ia % ib; e.lat = 34;
            end else begin
               e.res = a / b; e.hi = a % b; e.lat = 34;
            end
         end
`endif
         default: e.e = 1;
      endcase
`ifdef SEQ_ALU_DIV_EN
      if (op == 4'd15) begin e.z = 0; e.n = 0; end
`else
      if (op >= 4'd14) begin e.z = 0; e.n = 0; end
`endif
      else begin e.z = (e.res == 0); e.n = e.res[31]; end
      return e;
   endfunction

   task automatic run_op(input logic [3:0] op, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
      exp_t e;
      int cyc;
      sb_q.push_back(model(op, sg, a, b));
      @(negedge clk);
      start = 1; operation = op; sign = sg; A = a; B = b;
      @(posedge clk); #1;
      start = 0; operation = 4'($urandom); A = $urandom; B = $urandom; sign = ~sg;
      check("busy_after_accept", {63'b0, busy}, 1);
      cyc = 1;
      while (!done && cyc < 100) begin
         if (cyc == inj) begin start = 1; operation = 4'd11; A = 32'h1234; B = 32'h1; end
         @(posedge clk); #1;
         start = 0;
         cyc++;
      end
      check("done_seen", {63'b0, done}, 1);
      e = sb_q.pop_front();
      check($sformatf("latency op%0d", op), 64'(cyc), 64'(e.lat));
      check($sformatf("res op%0d a=%h b=%h", op, a, b), {32'b0, respuesta}, {32'b0, e.res});
      check($sformatf("hi op%0d", op), {32'b0, outHigh}, {32'b0, e.hi});
      check($sformatf("flags ZNCVE op%0d a=%h b=%h", op, a, b), {59'b0, Z, N, C, V, err},
            {59'b0, e.z, e.n, e.c, e.v, e.e});
      check("busy_at_done", {63'b0, busy}, 1);
      @(posedge clk); #1;
      check("done_one_cycle", {63'b0, done}, 0);
      check("busy_cleared", {63'b0, busy}, 0);
   endtask

   initial begin
      int seen;
      logic [3:0] rop;
      logic [31:0] ra, rb;
      reset = 1; start = 0; sign = 0; operation = 0; A = 0; B = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {busy, done, Z, N, C, V, err, respuesta, outHigh}, '0);
      reset = 0;

      run_op(4'd11, 1, 32'h7FFFFFFF, 32'h1, 0);
      run_op(4'd12, 0, 32'd2, 32'd3, 0);
      run_op(4'd12, 0, 32'd3, 32'd3, 0);
      run_op(4'd12, 1, 32'h80000000, 32'h1, 0);
      run_op(4'd11, 0, 32'hFFFFFFFF, 32'h1, 0);
      run_op(4'd5, 0, 32'h0F0F0000, 32'h00F0F0F0, 0);
      run_op(4'd6, 1, 32'hFFFFFFFF, 32'h0, 0);
      run_op(4'd7, 0, 32'hC0000001, 32'd1, 0);
      run_op(4'd7, 0, 32'hC0000001, 32'd0, 0);
      run_op(4'd8, 0, 32'h00000003, 32'd2, 0);
      run_op(4'd9, 0, 32'h80000010, 32'd5, 0);
      run_op(4'd10, 0, 32'hABCD1234, 32'd0, 0);
      run_op(4'd13, 1, 32'hFFFFFFFD, 32'd7, 0);
      run_op(4'd13, 0, 32'h00010000, 32'h00010000, 0);
      run_op(4'd14, 1, 32'hFFFFFFF9, 32'd2, 0);
      run_op(4'd14, 0, 32'd100, 32'd0, 0);
      run_op(4'd14, 1, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(4'd14, 0, 32'hFFFFFFFF, 32'd10, 0);
      run_op(4'd15, 0, 32'h5, 32'h6, 0);
      run_op(4'd0, 0, 32'h0, 32'h6, 0);
      run_op(4'd13, 0, 32'd1000, 32'd3000, 5);

      for (int i = 0; i < 20; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = (i % 5 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
         run_op(rop, 1'($urandom), ra, rb, 0);
      end

      run_op(4'd13, 0, 32'hFFFF0000, 32'h00012345, 0);
      @(negedge clk);
      start = 1; operation = 4'd13; sign = 0; A = 32'd5; B = 32'd9;
      @(posedge clk); #1;
      start = 0;
      repeat (9) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      reset = 0;
      check("abort_outputs", {busy, done, Z, N, C, V, err, respuesta, outHigh}, '0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      check("abort_no_done", 64'(seen), 0);
      run_op(4'd9, 0, 32'h80000000, 32'd4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
